// File: rtl/nbody_pair_sched.sv
// Pair scheduler for one N-body timestep: issues (i,j) position/mass reads and
// delays pair tags to the velocity read, accumulate and writeback points.
// Build option: define NBODY_SKIP_SELF_EN to omit i==j pairs.
module nbody_pair_sched #(
   parameter int unsigned BODIES          = 512,
   parameter int unsigned BODY_ADDR_WIDTH = $clog2(BODIES),
   parameter int unsigned PIPE_LATENCY    = 123,
   parameter int unsigned ADD_LATENCY     = 20
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       abort,
   input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
   output logic                       busy,
   output logic                       done,
   output logic                       issue_valid,
   output logic [BODY_ADDR_WIDTH-1:0] issue_i,
   output logic [BODY_ADDR_WIDTH-1:0] issue_j,
   output logic                       issue_self,
   output logic                       vrd_valid,
   output logic [BODY_ADDR_WIDTH-1:0] vrd_addr,
   output logic                       acc_valid,
   output logic                       acc_self,
   output logic                       wb_valid,
   output logic [BODY_ADDR_WIDTH-1:0] wb_addr
);

   localparam int unsigned W       = BODY_ADDR_WIDTH;
   localparam int unsigned DEPTH   = PIPE_LATENCY + ADD_LATENCY;
   localparam int unsigned TAG_W   = W + 3;
   localparam int unsigned VRD_TAP = PIPE_LATENCY - 2;
   localparam int unsigned ACC_TAP = PIPE_LATENCY - 1;
   localparam int unsigned WB_TAP  = DEPTH - 1;

   // Tag bit positions: {valid, last, self, j}
   localparam int unsigned TV = W + 2;
   localparam int unsigned TL = W + 1;
   localparam int unsigned TS = W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

`ifdef NBODY_SKIP_SELF_EN
   localparam logic [W-1:0] FIRST_J    = W'(1);
   localparam logic         FIRST_SELF = 1'b0;
`else
   localparam logic [W-1:0] FIRST_J    = '0;
   localparam logic         FIRST_SELF = 1'b1;
`endif

   logic [1:0]       r_state;
   logic [W:0]       r_nm1;
   logic             r_busy;
   logic             r_done;
   logic             r_issue_valid;
   logic [W-1:0]     r_issue_i;
   logic [W-1:0]     r_issue_j;
   logic             r_issue_self;
   logic             r_issue_last;
   logic [TAG_W-1:0] r_line [DEPTH];

   logic [1:0]       w_state_nxt;
   logic [W:0]       w_nm1_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_iv_nxt;
   logic [W-1:0]     w_i_nxt;
   logic [W-1:0]     w_j_nxt;
   logic             w_self_nxt;
   logic             w_last_nxt;

   logic [W:0]       w_n_clamp;
   logic [W:0]       w_nm1_start;
   logic [W-1:0]     w_pi_nxt;
   logic [W-1:0]     w_pj_nxt;
   logic             w_pself_nxt;
   logic             w_plast_nxt;
   logic             w_tail_last;

   // Requested body count, clamped to the address space
   always_comb begin
      w_n_clamp = num_bodies;
      if (num_bodies > (W+1)'(BODIES)) begin
         w_n_clamp = (W+1)'(BODIES);
      end
      w_nm1_start = w_n_clamp - (W+1)'(1);
   end

`ifdef NBODY_SKIP_SELF_EN
   logic [W:0] w_i_ext;
   logic [W:0] w_j_ext;
   logic [W:0] w_j_cand;

   // Successor pair; j steps over i so the diagonal is never issued
   always_comb begin
      w_i_ext  = {1'b0, r_issue_i};
      w_j_ext  = {1'b0, r_issue_j};
      w_pi_nxt = r_issue_i;
      w_pj_nxt = '0;
      w_j_cand = w_j_ext + (W+1)'(1);
      if (w_j_cand == w_i_ext) begin
         w_j_cand = w_j_ext + (W+1)'(2);
      end
      if (w_j_cand > r_nm1) begin
         w_pi_nxt = W'(w_i_ext + (W+1)'(1));
      end else begin
         w_pj_nxt = W'(w_j_cand);
      end
      w_plast_nxt = ({1'b0, w_pi_nxt} == r_nm1) &&
                    (({1'b0, w_pj_nxt} + (W+1)'(1)) == r_nm1);
      w_pself_nxt = 1'b0;
   end
`else
   logic [W:0] w_j_ext;

   // Successor pair; j is the inner loop and wraps at N-1
   always_comb begin
      w_j_ext  = {1'b0, r_issue_j};
      w_pi_nxt = r_issue_i;
      w_pj_nxt = '0;
      if (w_j_ext == r_nm1) begin
         w_pi_nxt = W'({1'b0, r_issue_i} + (W+1)'(1));
      end else begin
         w_pj_nxt = W'(w_j_ext + (W+1)'(1));
      end
      w_plast_nxt = ({1'b0, w_pi_nxt} == r_nm1) && ({1'b0, w_pj_nxt} == r_nm1);
      w_pself_nxt = (w_pi_nxt == w_pj_nxt);
   end
`endif

   assign w_tail_last = r_line[WB_TAP][TV] & r_line[WB_TAP][TL];

   // Next state and next registered outputs
   always_comb begin
      w_state_nxt = r_state;
      w_nm1_nxt   = r_nm1;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_iv_nxt    = 1'b0;
      w_i_nxt     = '0;
      w_j_nxt     = '0;
      w_self_nxt  = 1'b0;
      w_last_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (num_bodies >= (W+1)'(2)) begin
                  w_state_nxt = S_ISSUE;
                  w_nm1_nxt   = w_nm1_start;
                  w_busy_nxt  = 1'b1;
                  w_iv_nxt    = 1'b1;
                  w_j_nxt     = FIRST_J;
                  w_self_nxt  = FIRST_SELF;
               end else begin
                  w_done_nxt = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            w_busy_nxt = 1'b1;
            if (r_issue_last) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_iv_nxt   = 1'b1;
               w_i_nxt    = w_pi_nxt;
               w_j_nxt    = w_pj_nxt;
               w_self_nxt = w_pself_nxt;
               w_last_nxt = w_plast_nxt;
            end
         end
         S_DRAIN: begin
            if (w_tail_last) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end else begin
               w_busy_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      if (abort) begin
         w_state_nxt = S_IDLE;
         w_busy_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
         w_iv_nxt    = 1'b0;
         w_i_nxt     = '0;
         w_j_nxt     = '0;
         w_self_nxt  = 1'b0;
         w_last_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_nm1         <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_issue_valid <= 1'b0;
         r_issue_i     <= '0;
         r_issue_j     <= '0;
         r_issue_self  <= 1'b0;
         r_issue_last  <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_nm1         <= w_nm1_nxt;
         r_busy        <= w_busy_nxt;
         r_done        <= w_done_nxt;
         r_issue_valid <= w_iv_nxt;
         r_issue_i     <= w_i_nxt;
         r_issue_j     <= w_j_nxt;
         r_issue_self  <= w_self_nxt;
         r_issue_last  <= w_last_nxt;
      end
   end

   // Tag delay line matched to the FP pipeline; invalid slots carry all zeros
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            r_line[k] <= '0;
         end
      end else begin
         r_line[0] <= {r_issue_valid, r_issue_last, r_issue_self, r_issue_j};
         for (int k = 1; k < int'(DEPTH); k++) begin
            r_line[k] <= r_line[k-1];
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign issue_valid = r_issue_valid;
   assign issue_i     = r_issue_i;
   assign issue_j     = r_issue_j;
   assign issue_self  = r_issue_self;
   assign vrd_valid   = r_line[VRD_TAP][TV];
   assign vrd_addr    = r_line[VRD_TAP][W-1:0];
   assign acc_valid   = r_line[ACC_TAP][TV];
   assign acc_self    = r_line[ACC_TAP][TS];
   assign wb_valid    = r_line[WB_TAP][TV];
   assign wb_addr     = r_line[WB_TAP][W-1:0];

endmodule
